// File: rtl/image_pattern_source_pkg.sv
// -----------------------------------------------------------------------------
// image_pattern_source_pkg
// Shared image-bus definitions for the pattern source and its raster counter.
//   IMG_DATA_W    : pixel data width D of the default image spec
//   IMG_PAYLOAD_W : payload width, {STOP, START, data[D-1:0]}
//   PATTERN_*     : pattern select codes
//   state_e       : pattern source FSM states
// Macro IMG_PAYLOAD(start, stop, data) assembles a payload word.
// -----------------------------------------------------------------------------
package image_pattern_source_pkg;

    localparam int IMG_DATA_W    = 8;
    localparam int IMG_PAYLOAD_W = IMG_DATA_W + 2;

    localparam logic [1:0] PATTERN_GRADIENT = 2'd0;
    localparam logic [1:0] PATTERN_CHECKER  = 2'd1;
    localparam logic [1:0] PATTERN_SOLID    = 2'd2;
    localparam logic [1:0] PATTERN_RESERVED = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// Payload layout: bit D+1 = STOP, bit D = START, bits D-1:0 = pixel data.
`define IMG_PAYLOAD(start, stop, data) {(stop), (start), (data)}

// File: rtl/image_raster_counter.sv
// -----------------------------------------------------------------------------
// image_raster_counter
// Raster x/y position counter with line/frame wrap and first/last pixel flags.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clear_i    : return to x = 0, y = 0
//   advance_i  : step to the next pixel in raster order
//   x_o, y_o   : current position
//   first_o    : position is (0, 0)
//   last_o     : position is (Width-1, Height-1)
// -----------------------------------------------------------------------------
module image_raster_counter #(
    parameter int Width      = 16,
    parameter int Height     = 16,
    parameter int CoordWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  advance_i,
    output logic [CoordWidth-1:0] x_o,
    output logic [CoordWidth-1:0] y_o,
    output logic                  first_o,
    output logic                  last_o
);

    localparam logic [CoordWidth-1:0] XLast = CoordWidth'(Width - 1);
    localparam logic [CoordWidth-1:0] YLast = CoordWidth'(Height - 1);

    logic [CoordWidth-1:0] x_q, x_d;
    logic [CoordWidth-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == XLast) begin
                x_d = '0;
                y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign first_o = (x_q == '0) && (y_q == '0);
    assign last_o  = (x_q == XLast) && (y_q == YLast);

endmodule

// File: rtl/image_pattern_source.sv
// -----------------------------------------------------------------------------
// image_pattern_source
// Synthetic raster frame generator on the image bus; one frame per request.
//   clock_i           : system clock
//   reset_i           : synchronous active-high reset
//   pattern_select_i  : 0 gradient, 1 checkerboard, 2 solid, 3 reserved
//   solid_value_i     : pixel value for the solid pattern
//   busy_o            : frame in progress
//   image_valid_o     : bus Valid
//   image_payload_o   : bus Payload {STOP, START, data}
//   image_error_o     : bus Error (reserved pattern frame)
//   image_ready_i     : bus Ready
//   image_request_i   : bus Request (level, sampled in IDLE)
//   image_cancel_i    : bus Cancel (aborts from any state)
//   frame_count_o     : completed frames mod 256
//                       (only with IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN)
// With IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN the gradient is offset by the
// frame count.
//
// state     | meaning
// ST_IDLE   | bus idle, counters held at 0, waiting for Request
// ST_ACTIVE | streaming pixels of the current frame, Valid high
// -----------------------------------------------------------------------------
module image_pattern_source
    import image_pattern_source_pkg::*;
#(
    parameter int OutDataWidth = IMG_DATA_W,
    parameter int Width        = 16,
    parameter int Height       = 16,
    parameter int CoordWidth   = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [1:0]              pattern_select_i,
    input  logic [OutDataWidth-1:0] solid_value_i,
    output logic                    busy_o,
    output logic                    image_valid_o,
    output logic [OutDataWidth+1:0] image_payload_o,
    output logic                    image_error_o,
    input  logic                    image_ready_i,
    input  logic                    image_request_i,
    input  logic                    image_cancel_i
`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
    ,
    output logic [7:0]              frame_count_o
`endif
);

    state_e                  state_q, state_d;
    logic [1:0]              pat_q, pat_d;
    logic [OutDataWidth-1:0] solid_q, solid_d;
    logic                    err_q, err_d;
    logic                    cnt_clear;
    logic                    cnt_advance;
    logic [CoordWidth-1:0]   x_w, y_w;
    logic                    first_w, last_w;
    logic [OutDataWidth-1:0] grad_w;
    logic [OutDataWidth-1:0] data_w;
    logic                    active_w;

`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
    logic [7:0]              fc_q, fc_d;
`endif

    image_raster_counter #(
        .Width      (Width),
        .Height     (Height),
        .CoordWidth (CoordWidth)
    ) u_raster (
        .clk_i     (clock_i),
        .rst_i     (reset_i),
        .clear_i   (cnt_clear),
        .advance_i (cnt_advance),
        .x_o       (x_w),
        .y_o       (y_w),
        .first_o   (first_w),
        .last_o    (last_w)
    );

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        err_d       = err_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
        fc_d        = fc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (image_request_i && !image_cancel_i) begin
                    state_d = ST_ACTIVE;
                    pat_d   = pattern_select_i;
                    solid_d = solid_value_i;
                    err_d   = (pattern_select_i == PATTERN_RESERVED);
                end
            end
            ST_ACTIVE: begin
                // Cancel wins over a coincident STOP transfer: no frame count.
                if (image_cancel_i) begin
                    state_d   = ST_IDLE;
                    err_d     = 1'b0;
                    cnt_clear = 1'b1;
                end else if (image_ready_i) begin
                    cnt_advance = 1'b1;
                    if (last_w) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b0;
`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
                        fc_d    = fc_q + 8'd1;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            solid_q <= '0;
            err_q   <= 1'b0;
`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
            fc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            err_q   <= err_d;
`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
            fc_q    <= fc_d;
`endif
        end
    end

    // Operands truncated before the add; equal to the full sum mod 2^D.
`ifdef IMAGE_PATTERN_SOURCE_FRAME_COUNT_EN
    assign grad_w = OutDataWidth'(x_w) + OutDataWidth'(y_w) + OutDataWidth'(fc_q);
    assign frame_count_o = fc_q;
`else
    assign grad_w = OutDataWidth'(x_w) + OutDataWidth'(y_w);
`endif

    always_comb begin
        data_w = '0;
        case (pat_q)
            PATTERN_GRADIENT: data_w = grad_w;
            PATTERN_CHECKER:  data_w = {OutDataWidth{x_w[0] ^ y_w[0]}};
            PATTERN_SOLID:    data_w = solid_q;
            default:          data_w = '0;
        endcase
    end

    assign active_w        = (state_q == ST_ACTIVE);
    assign busy_o          = active_w;
    assign image_valid_o   = active_w;
    assign image_error_o   = err_q;
    assign image_payload_o = active_w ? `IMG_PAYLOAD(first_w, last_w, data_w) : '0;

endmodule
